rreq_multi_ctrl: RTL and testbench

Clocked, N-channel successor to the single-channel `Rreq` request controller. Each channel drives one request output from a local go signal and the downstream acknowledge. Each channel runs in one of two modes:
- 4-phase: inverted-input C-element behaviour.
- 2-phase: transition signalling.

The block adds input synchronisers, a one-deep go buffer in 2-phase mode, sticky protocol-error flags and per-channel completed-handshake counters. It sits between the pipeline-stage logic and asynchronous neighbours that drive `r_ack`.

---
 rtl/rreq_multi_ctrl.sv | 125 ++++++++++++
 tb/tb_rreq_multi_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rreq_multi_ctrl.sv
// N-channel clocked request controller: per-channel 4-phase (inverted-input C-element)
// or 2-phase (transition) request generation with sync inputs, error flags and counters.
module rreq_multi_ctrl #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       go_lm,
  input  logic [CHANNELS-1:0]       r_ack,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      err_clr,
  output logic [CHANNELS-1:0]       r_req,
  output logic [CHANNELS-1:0]       err,
  output logic [CHANNELS*CNT_W-1:0] hs_cnt
);

  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] b;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign a = go_lm;
      assign b = r_ack;
    end else begin : g_sync
      logic [CHANNELS-1:0] a_sync_reg [SYNC_STAGES];
      logic [CHANNELS-1:0] b_sync_reg [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            a_sync_reg[s] <= '0;
            b_sync_reg[s] <= '0;
          end
        end else begin
          a_sync_reg[0] <= go_lm;
          b_sync_reg[0] <= r_ack;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            a_sync_reg[s] <= a_sync_reg[s-1];
            b_sync_reg[s] <= b_sync_reg[s-1];
          end
        end
      end

      assign a = a_sync_reg[SYNC_STAGES-1];
      assign b = b_sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             r_req_reg, r_req_next;
      logic             go_pend_reg, go_pend_next;
      logic             mode_reg, mode_next;
      logic             err_reg;
      logic             a_d_reg, b_d_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             idle, pending, go_ev, b_chg, err_ev, inc;

      always_comb begin
        // Mode may only change while the channel is quiescent in its current protocol.
        idle         = mode_reg ? ((r_req_reg == b[gi]) && !go_pend_reg)
                                : (!r_req_reg && !b[gi]);
        mode_next    = idle ? mode[gi] : mode_reg;
        pending      = r_req_reg ^ b[gi];
        go_ev        = a[gi] ^ a_d_reg;
        b_chg        = b[gi] ^ b_d_reg;
        r_req_next   = r_req_reg;
        go_pend_next = go_pend_reg;
        err_ev       = 1'b0;
        inc          = 1'b0;
        if (!mode_next) begin
          r_req_next = (~a[gi] & ~b[gi]) | (r_req_reg & ~(a[gi] & b[gi]));
          err_ev     = b_chg & (b[gi] ? ~r_req_reg : r_req_reg);
          inc        = r_req_reg & ~r_req_next;
        end else begin
          // A b change that leaves r_req != b means the channel was idle before it.
          err_ev = b_chg & pending;
          inc    = b_chg & ~pending;
          if (!pending) begin
            if (go_pend_reg) begin
              r_req_next   = ~r_req_reg;
              go_pend_next = go_ev;
            end else if (go_ev) begin
              r_req_next = ~r_req_reg;
            end
          end else if (go_ev) begin
            if (go_pend_reg) err_ev = 1'b1;
            else             go_pend_next = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_req_reg   <= 1'b0;
          go_pend_reg <= 1'b0;
          mode_reg    <= 1'b0;
          err_reg     <= 1'b0;
          a_d_reg     <= 1'b0;
          b_d_reg     <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          a_d_reg <= a[gi];
          b_d_reg <= b[gi];
          if (en[gi]) begin
            r_req_reg   <= r_req_next;
            go_pend_reg <= go_pend_next;
            mode_reg    <= mode_next;
            err_reg     <= err_ev | (err_reg & ~err_clr);
            cnt_reg     <= cnt_reg + CNT_W'(inc);
          end
        end
      end

      assign r_req[gi]                    = r_req_reg;
      assign err[gi]                      = err_reg;
      assign hs_cnt[gi*CNT_W +: CNT_W]    = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_rreq_multi_ctrl.sv
// Scoreboard bench for rreq_multi_ctrl: a protocol-level model predicts outputs
// per clock edge, a monitor pops and compares after every edge.
module tb_rreq_multi_ctrl;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [CH-1:0] go_lm, r_ack, mode, en;
  logic          err_clr;
  logic [CH-1:0] r_req, err;
  logic [CH*CW-1:0] hs_cnt;

  rreq_multi_ctrl #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .go_lm(go_lm), .r_ack(r_ack), .mode(mode), .en(en),
    .err_clr(err_clr), .r_req(r_req), .err(err), .hs_cnt(hs_cnt)
  );

  typedef struct {
    logic [CH-1:0]    rq;
    logic [CH-1:0]    er;
    logic [CH*CW-1:0] cnt;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Reference state, one entry per channel
  bit            m_rq[CH], m_er[CH], m_gp[CH], m_am[CH], m_ad[CH], m_bd[CH];
  int            m_cnt[CH];
  logic [CH-1:0] hist_a[$], hist_b[$];

  // Predict the state after the coming rising edge from the pins currently driven.
  task automatic model_edge();
    logic [CH-1:0] av, bv;
    bit a, b, idle, md, ev, done, nrq, was_pend, pend_now, go;
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        m_rq[i] = 0; m_er[i] = 0; m_gp[i] = 0; m_am[i] = 0;
        m_ad[i] = 0; m_bd[i] = 0; m_cnt[i] = 0;
      end
      hist_a = {};
      hist_b = {};
      for (int s = 0; s < SS; s++) begin
        hist_a.push_back('0);
        hist_b.push_back('0);
      end
    end else begin
      hist_a.push_back(go_lm);
      hist_b.push_back(r_ack);
      av = hist_a.pop_front();
      bv = hist_b.pop_front();
      for (int i = 0; i < CH; i++) begin
        a = av[i];
        b = bv[i];
        if (en[i]) begin
          idle = m_am[i] ? (m_rq[i] == b && !m_gp[i]) : (!m_rq[i] && !b);
          md   = idle ? mode[i] : m_am[i];
          ev   = 0;
          done = 0;
          nrq  = m_rq[i];
          if (!md) begin
            if (a == b) nrq = !a;
            ev   = (b != m_bd[i]) && (b != m_rq[i]);
            done = m_rq[i] && !nrq;
          end else begin
            was_pend = (m_rq[i] != m_bd[i]);
            pend_now = (m_rq[i] != b);
            go       = (a != m_ad[i]);
            if (b != m_bd[i]) begin
              if (was_pend) done = 1;
              else          ev = 1;
            end
            if (!pend_now && m_gp[i]) begin
              nrq     = !m_rq[i];
              m_gp[i] = go;
            end else if (!pend_now && go) begin
              nrq = !m_rq[i];
            end else if (pend_now && go) begin
              if (m_gp[i]) ev = 1;
              else         m_gp[i] = 1;
            end
          end
          m_er[i] = ev ? 1'b1 : (err_clr ? 1'b0 : m_er[i]);
          if (done) m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
          m_rq[i] = nrq;
          m_am[i] = md;
        end
        m_ad[i] = a;
        m_bd[i] = b;
      end
    end
    for (int i = 0; i < CH; i++) begin
      e.rq[i] = m_rq[i];
      e.er[i] = m_er[i];
      e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
    end
    e.cyc = cyc_no;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_edge();
    cyc_no++;
    @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Monitor: compare after every edge that has a prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (r_req !== e.rq) begin
          errors++;
          $display("FAIL r_req cycle %0d: got %b expected %b", e.cyc, r_req, e.rq);
        end
        if (err !== e.er) begin
          errors++;
          $display("FAIL err cycle %0d: got %b expected %b", e.cyc, err, e.er);
        end
        if (hs_cnt !== e.cnt) begin
          errors++;
          $display("FAIL hs_cnt cycle %0d: got %h expected %h", e.cyc, hs_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; go_lm = '0; r_ack = '0; mode = '0; en = '1; err_clr = 1'b0;
    tick_n(3);
    rst = 1'b1;
    tick_n(3);

    $display("scenario: 4-phase cycle on ch0");
    r_ack[0] = 1'b1; tick_n(4);
    go_lm[0] = 1'b1; tick_n(4);
    r_ack[0] = 1'b0; go_lm[0] = 1'b0; tick_n(4);

    $display("scenario: 4-phase protocol error and err_clr on ch1");
    r_ack[1] = 1'b1; tick_n(4);
    r_ack[1] = 1'b0; tick_n(5);
    err_clr = 1'b1; tick_n(1); err_clr = 1'b0; tick_n(2);
    r_ack[1] = 1'b1; tick_n(4);
    r_ack[1] = 1'b0; tick_n(2);
    err_clr = 1'b1; tick_n(1); err_clr = 1'b0; tick_n(3);

    $display("scenario: 2-phase back-to-back go on ch2");
    r_ack[2] = 1'b1; go_lm[2] = 1'b1; tick_n(4);
    r_ack[2] = 1'b0; mode[2] = 1'b1; tick_n(4);
    go_lm[2] = 1'b0; tick_n(1);
    go_lm[2] = 1'b1; tick_n(4);
    r_ack[2] = 1'b1; tick_n(4);
    r_ack[2] = 1'b0; tick_n(4);
    go_lm[2] = 1'b0; tick_n(1);
    go_lm[2] = 1'b1; tick_n(1);
    go_lm[2] = 1'b0; tick_n(4);
    r_ack[2] = 1'b1; tick_n(4);
    r_ack[2] = 1'b0; tick_n(4);

    $display("scenario: counter wrap on ch3");
    repeat (5) begin
      r_ack[3] = 1'b1; go_lm[3] = 1'b1; tick_n(4);
      r_ack[3] = 1'b0; go_lm[3] = 1'b0; tick_n(4);
    end

    $display("scenario: enable freeze and mode switch");
    en[0] = 1'b0; r_ack[0] = 1'b1; go_lm[0] = 1'b1; tick_n(5);
    en[0] = 1'b1; tick_n(3);
    r_ack[0] = 1'b0; go_lm[0] = 1'b0; tick_n(4);
    en[2] = 1'b0; go_lm[2] = ~go_lm[2]; tick_n(5);
    en[2] = 1'b1; tick_n(3);
    mode[0] = 1'b1; tick_n(3);
    r_ack[0] = 1'b1; go_lm[0] = 1'b1; tick_n(4);
    r_ack[0] = 1'b0; tick_n(4);
    go_lm[0] = 1'b0; tick_n(4);
    r_ack[0] = 1'b1; tick_n(4);

    $display("scenario: reset mid-operation");
    go_lm[0] = 1'b1; go_lm[2] = ~go_lm[2]; r_ack[1] = 1'b1; tick_n(4);
    rst = 1'b0; tick_n(1);
    go_lm = '0; r_ack = '0; mode = '0; r_ack[0] = 1'b1; tick_n(1);
    rst = 1'b1; tick_n(6);
    r_ack[0] = 1'b0; tick_n(4);

    $display("scenario: random pin activity");
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0)  go_lm[i] = ~go_lm[i];
        if ($urandom_range(0, 5) == 0)  r_ack[i] = ~r_ack[i];
        if ($urandom_range(0, 39) == 0) mode[i]  = ~mode[i];
        en[i] = ($urandom_range(0, 9) != 0);
      end
      err_clr = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 249) != 0);
      tick();
    end

    $display("scenario: random cooperative neighbours");
    rst = 1'b1; err_clr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 4) == 0)  go_lm[i] = ~go_lm[i];
        if ($urandom_range(0, 2) == 0)  r_ack[i] = r_req[i];
        if ($urandom_range(0, 59) == 0) mode[i]  = ~mode[i];
        en[i] = ($urandom_range(0, 14) != 0);
      end
      err_clr = ($urandom_range(0, 29) == 0);
      tick();
    end

    tick_n(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
